// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the direct-mapped parameter cache.
//   state_e : controller FSM states
//   off_w   : word-offset field width for a given words-per-line count
//   idx_w   : set-index field width for a given line count
//   tag_w   : tag field width left over from the word address
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL,
    WRITE_MEM,
    RESPOND
  } state_e;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/tag/data storage for a direct-mapped cache.
//   clk, rst      : clock, asynchronous active-high reset (clears valid bits only)
//   flush_i       : clear every valid bit at the next edge
//   idx_i         : set index shared by the read and write ports
//   rd_off_i      : word offset for the combinational read port
//   rd_valid_o, rd_tag_o, rd_data_o : contents of the indexed line / word
//   word_we_i, wr_off_i, word_wdata_i : single-word write into the indexed line
//   tag_we_i, tag_i : write the line tag and mark the line valid
module cache_line_array
  import cache_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_SETS = 128,
  parameter int WORDS    = 8,
  parameter int TAG_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [idx_w(NUM_SETS)-1:0]   idx_i,
  input  logic [off_w(WORDS)-1:0]      rd_off_i,
  output logic                         rd_valid_o,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [DATA_W-1:0]            rd_data_o,
  input  logic                         word_we_i,
  input  logic [off_w(WORDS)-1:0]      wr_off_i,
  input  logic [DATA_W-1:0]            word_wdata_i,
  input  logic                         tag_we_i,
  input  logic [TAG_W-1:0]             tag_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [DATA_W-1:0]   data_mem [NUM_SETS*WORDS];

  // Only the valid bits need a known state; tags and data are qualified by them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_mem[idx_i] <= tag_i;
    end
    if (word_we_i) begin
      data_mem[{idx_i, wr_off_i}] <= word_wdata_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_tag_o   = tag_mem[idx_i];
  assign rd_data_o  = data_mem[{idx_i, rd_off_i}];

endmodule

// File: rtl/param_cache.sv
// param_cache: direct-mapped, write-through / no-write-allocate word cache.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : invalidate all lines (honoured only while idle)
//   req_*      : request side (valid/write/addr/wdata in, ready out)
//   resp_*     : one-cycle completion pulse with read data (0 for writes)
//   mem_*      : memory side; mem_req held until mem_gnt, refill beats
//                arrive on mem_rvalid/mem_rdata in word order
module param_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int NUM_SETS = 128,
  parameter int WORDS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush
);

  localparam int OW = off_w(WORDS);
  localparam int IW = idx_w(NUM_SETS);
  localparam int TW = tag_w(ADDR_W, NUM_SETS, WORDS);
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [OW-1:0]     cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [OW-1:0]     off;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic              rd_valid;
  logic [TW-1:0]     rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              accept;
  logic              flush_clr;
  logic              word_we;
  logic [OW-1:0]     wr_off;
  logic [DATA_W-1:0] word_wdata;
  logic              tag_we;

  assign off = addr_q[OW-1:0];
  assign idx = addr_q[OW+IW-1:OW];
  assign tag = addr_q[ADDR_W-1:OW+IW];
  assign hit = rd_valid && (rd_tag == tag);

  // Ready is held low while reset is asserted so nothing is accepted under it.
  assign req_ready = (state_q == IDLE) && !flush && !rst;
  assign accept    = req_valid && req_ready;

  cache_line_array #(
    .DATA_W  (DATA_W),
    .NUM_SETS(NUM_SETS),
    .WORDS   (WORDS),
    .TAG_W   (TW)
  ) u_lines (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_clr),
    .idx_i       (idx),
    .rd_off_i    (off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .word_we_i   (word_we),
    .wr_off_i    (wr_off),
    .word_wdata_i(word_wdata),
    .tag_we_i    (tag_we),
    .tag_i       (tag)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    flush_clr    = 1'b0;
    word_we      = 1'b0;
    wr_off       = off;
    word_wdata   = wdata_q;
    tag_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_clr = 1'b1;
        end else if (accept) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (write_q) begin
          // Write-through: update the cached copy only on a hit, always write memory.
          word_we     = hit;
          state_d     = WRITE_MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
        end else if (hit) begin
          state_d = RESPOND;
        end else begin
          state_d    = REFILL_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
        end
      end
      REFILL_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        if (mem_rvalid) begin
          word_we    = 1'b1;
          wr_off     = cnt_q;
          word_wdata = mem_rdata;
          cnt_d      = cnt_q + 1'b1;
          // The line becomes valid only once the final beat has landed.
          if (cnt_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            cnt_d   = '0;
            state_d = RESPOND;
          end
        end
      end
      WRITE_MEM: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESPOND;
        end
      end
      RESPOND: begin
        // The array already holds the refilled or hit word, so read it here.
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? '0 : rd_data;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      write_q <= req_write;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameter ADDR_W, default 16, meaning word-address width.
REQ-002 Parameter DATA_W, default 16, meaning word width.
REQ-003 Parameter NUM_SETS, default 128, meaning direct-mapped lines; power of two, at least 2.
REQ-004 Parameter WORDS, default 8, meaning words per line; power of two, at least 2.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-006 Port clk, input, 1, meaning the clock; port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 Request-side ports SHALL be: req_valid in 1 (request present); req_write in 1 (1 = write); req_addr in ADDR_W (word address); req_wdata in DATA_W (write data); req_ready out 1 (request accepted this cycle); resp_valid out 1 (one-cycle completion pulse); resp_rdata out DATA_W (read data).
REQ-008 Memory-side ports SHALL be: mem_req out 1 (request, held until granted); mem_we out 1 (write request); mem_addr out ADDR_W (memory address); mem_wdata out DATA_W (write data); mem_gnt in 1 (request taken); mem_rvalid in 1 (refill beat present); mem_rdata in DATA_W (refill beat data).
REQ-009 Port flush, input, 1, meaning invalidate all lines.

Function
REQ-010 Address split SHALL be: offset = addr[OW-1:0] with OW = log2(WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits. Per line, storage holds a valid bit, the tag, and WORDS data words.
REQ-011 FSM states SHALL be IDLE, LOOKUP, REFILL_REQ, REFILL, WRITE_MEM, RESPOND.
REQ-012 req_ready SHALL be high only in IDLE with flush low; acceptance (req_valid && req_ready) latches addr, wdata and write, then enters LOOKUP.
REQ-013 Read hit (valid and tag equal in LOOKUP): go to RESPOND; resp_valid high for exactly one cycle with the addressed word; latency = 2 clock edges from the acceptance edge.
REQ-014 Read miss: go to REFILL_REQ; assert mem_req=1, mem_we=0, mem_addr = line-aligned address (offset bits zero) until mem_gnt.
REQ-015 On mem_gnt, go to REFILL; mem_req drops the next cycle.
REQ-016 In REFILL, the beat counter starts at 0, each mem_rvalid writes mem_rdata to word[counter] and increments the counter, and cycles without mem_rvalid hold state.
REQ-017 On beat WORDS-1, write the tag, set valid, and go to RESPOND; resp_rdata is the beat at the requested offset.
REQ-018 Writes SHALL be write-through, no-allocate: a hit in LOOKUP updates the cached word; hit or miss goes to WRITE_MEM with mem_req=1, mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata held until mem_gnt, then RESPOND (resp_valid as ack, resp_rdata=0).
REQ-019 A write miss SHALL leave the valid bit and tag unchanged.
REQ-020 flush high in IDLE SHALL clear all valid bits at the next edge and block acceptance that cycle; flush outside IDLE SHALL be ignored.
REQ-021 mem_rvalid outside REFILL and mem_gnt while mem_req is low SHALL be ignored.
REQ-022 Outputs SHALL be registered: resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata.

Reset
REQ-023 rst SHALL asynchronously force state IDLE, clear all valid bits and the beat counter, and drive resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; req_ready goes high after rst deasserts.
REQ-024 Reset during REFILL SHALL abandon the refill and leave that line invalid.
REQ-025 Tag and data contents SHALL NOT require reset.

Structure
REQ-026 Package cache_pkg SHALL hold the FSM state enum and log2-derived width helpers (offset, index, tag widths).
REQ-027 One sub-module, cache_line_array, SHALL hold the valid, tag and data storage, with per-word write enable, tag write, and flush-clear.

Verification
REQ-028 Cold read 0x0405 -> mem_req with mem_addr 0x0400; 8 beats of values 0xA0..0xA7 -> resp_valid once, resp_rdata 0xA5.
REQ-029 Then read 0x0402 -> hit, resp_valid 2 edges after acceptance with 0xA2, and no mem_req.
REQ-030 Write 0x0403 data 0xBEEF (hit) -> mem_we write to 0x0403 with 0xBEEF; a later read of 0x0403 hits with 0xBEEF.
REQ-031 Read 0x0805 (same index as 0x0405, tag 0x02) -> refill from 0x0800 and eviction; then read 0x0405 misses again.
REQ-032 Write miss to 0x1000 -> memory write issued; a subsequent read of 0x1000 misses.
REQ-033 Flush in IDLE then read 0x0402 -> miss; rst asserted mid-REFILL after beat 3 -> IDLE, outputs zero, and the line misses on the next read.
